and16_rr_arbiter: RTL and testbench
===================================

Name: and16_rr_arbiter

Overview:
- Shares one 16-bit bitwise-AND datapath among NREQ independent requesters.
- Each requester presents an operand pair (a, b) with a valid/ready handshake.
- A round-robin arbiter grants one requester per cycle; the result a & b is registered into a single-entry output buffer tagged with the requester id.
- The block sits between client units and the shared And16 datapath, so multiple clients can use one AND unit without starvation.

Parameters:
WIDTH, 16, operand/result width in bits
NREQ, 4, number of requesters (fixed at 4 for this revision)
IDW, 2, requester id width (log2 NREQ)

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
req_valid  input  NREQ  per-requester operand valid
req_a  input  NREQ*WIDTH  packed operand a; requester i at [i*WIDTH +: WIDTH]
req_b  input  NREQ*WIDTH  packed operand b; same packing
req_ready  output  NREQ  one-hot grant; at most one bit high per cycle
resp_valid  output  1  result buffer holds a valid result
resp_ready  input  1  consumer accepts result
resp_out  output  WIDTH  registered a & b of granted requester
resp_id  output  IDW  index of requester that produced resp_out
rr_ptr  output  IDW  current round-robin highest-priority index (status)
ops_count  output  16  completed request transfers, wraps 16'hFFFF -> 0

Behaviour:
- Reset (async, rst=1): resp_valid=0, resp_out=0, resp_id=0, rr_ptr=0, ops_count=0. req_ready=0 while rst is high. Any buffered result is discarded, and no transfer completes in a cycle where rst is high.
- can_accept = !resp_valid | resp_ready (combinational; req_ready depends on resp_ready in the same cycle).
- Arbitration (combinational): if can_accept and req_valid != 0, the winner g is the first i with req_valid[i]=1, searched in order rr_ptr, rr_ptr+1, ..., wrapping mod NREQ. req_ready[g]=1; all other req_ready bits are 0. No winner gives req_ready=0.
- Transfer: req_valid[g] & req_ready[g]. On the next edge:
  - resp_valid<=1, resp_out<=req_a[g] & req_b[g], resp_id<=g
  - rr_ptr<=(g+1) mod NREQ
  - ops_count<=ops_count+1
- Latency: exactly 1 cycle from transfer to resp_valid.
- Pointer hold: rr_ptr is unchanged in any cycle without a transfer.
- Hold: while resp_valid=1 and resp_ready=0, resp_out and resp_id are stable and req_ready is all zero.
- Drain without refill: resp_valid=1, resp_ready=1, no transfer -> resp_valid<=0; resp_out and resp_id keep their last values.
- Simultaneous drain and refill: resp_valid=1, resp_ready=1, transfer -> resp_valid stays 1 with the new result. This sustains full throughput of 1 op/cycle.
- Fairness: a requester holding req_valid continuously is granted within NREQ transfers.
- Requester rules: a requester keeps req_valid and its operands stable until granted. Deasserting req_valid before grant is permitted and simply withdraws the request.
- Width rules: bitwise AND only, no carry and no sign extension. rr_ptr wraps 3 -> 0 and ops_count wraps modulo 2^16.
- Mid-operation reset: resp_valid falls immediately on rst, even if resp_ready is low. On release, arbitration restarts at index 0.

Test Plan:
1. Single requester: rst, then req_valid=4'b0001, a0=16'h00FF, b0=16'hFFFF, resp_ready=1 -> req_ready=4'b0001 in the same cycle; next cycle resp_valid=1, resp_out=16'h00FF, resp_id=0, rr_ptr=1, ops_count=1.
2. Round-robin: all four requesters valid continuously with a_i=16'hFFFF, b_i=16'h1111*(i+1), resp_ready=1 -> grant order 0,1,2,3,0; resp_out sequence 1111, 2222, 3333, 4444, 1111; one result per cycle.
3. Backpressure: requesters 1 and 2 valid, resp_ready=0 for 3 cycles after the first result -> resp_out=result of requester 1 held stable and req_ready=0 for those cycles. Raise resp_ready: requester 2's result appears the next cycle with no bubble.
4. Pointer skip: rr_ptr=3, only requester 1 valid -> grant 1 (wraps 3 -> 0 -> 1); rr_ptr becomes 2.
5. Async reset mid-operation: resp_valid=1 with resp_ready=0, assert rst between clock edges -> resp_valid, resp_out, rr_ptr and ops_count go to 0 without waiting for an edge. After release, req_valid=4'b1000 gives the first grant to requester 3 and rr_ptr becomes 0.
6. Counter wrap: preload 65535 transfers, then one more -> ops_count=16'h0000; resp_out still correct for a=16'hAAAA, b=16'h0F0F -> 16'h0A0A.

Source files
------------

// File: rtl/and16_rr_arbiter.sv
// Round-robin front end for one shared 16-bit AND datapath serving NREQ requesters.
// One grant per cycle; the result lands in a single-entry buffer tagged with the winner id.
module and16_rr_arbiter #(
   parameter int WIDTH = 16,
   parameter int NREQ  = 4,
   parameter int IDW   = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req_valid,
   input  logic [NREQ*WIDTH-1:0] req_a,
   input  logic [NREQ*WIDTH-1:0] req_b,
   output logic [NREQ-1:0]       req_ready,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [WIDTH-1:0]      resp_out,
   output logic [IDW-1:0]        resp_id,
   output logic [IDW-1:0]        rr_ptr,
   output logic [15:0]           ops_count
);

   logic             can_accept;
   logic             found;
   logic [IDW-1:0]   win;
   logic [IDW-1:0]   idx;
   logic [WIDTH-1:0] sel_a;
   logic [WIDTH-1:0] sel_b;

   function automatic logic [WIDTH-1:0] and_op(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
      return a & b;
   endfunction

   // The buffer can take a new result if empty or being drained this cycle.
   assign can_accept = !resp_valid || resp_ready;

   // Search starts at rr_ptr; IDW-bit addition wraps modulo NREQ (NREQ == 2**IDW).
   always_comb begin
      found = 1'b0;
      win   = '0;
      idx   = '0;
      if (can_accept && !rst) begin
         for (int k = 0; k < NREQ; k++) begin
            idx = rr_ptr + IDW'(k);
            if (!found && req_valid[idx]) begin
               found = 1'b1;
               win   = idx;
            end
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (found) req_ready[win] = 1'b1;
   end

   assign sel_a = req_a[int'(win)*WIDTH +: WIDTH];
   assign sel_b = req_b[int'(win)*WIDTH +: WIDTH];

   // Stage boundary: granted operands -> registered result buffer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         resp_valid <= 1'b0;
         resp_out   <= '0;
         resp_id    <= '0;
         rr_ptr     <= '0;
         ops_count  <= '0;
      end else if (found) begin
         resp_valid <= 1'b1;
         resp_out   <= and_op(sel_a, sel_b);
         resp_id    <= win;
         rr_ptr     <= win + IDW'(1);
         ops_count  <= ops_count + 16'd1;
      end else if (resp_ready) begin
         resp_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_and16_rr_arbiter.sv
// Bench for and16_rr_arbiter: directed scenarios plus random traffic against a
// behavioural model of the grant/buffer rules.
module tb_and16_rr_arbiter;
   localparam int WIDTH = 16;
   localparam int NREQ  = 4;
   localparam int IDW   = 2;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [NREQ-1:0]       req_valid;
   logic [NREQ*WIDTH-1:0] req_a;
   logic [NREQ*WIDTH-1:0] req_b;
   logic [NREQ-1:0]       req_ready;
   logic                  resp_valid;
   logic                  resp_ready;
   logic [WIDTH-1:0]      resp_out;
   logic [IDW-1:0]        resp_id;
   logic [IDW-1:0]        rr_ptr;
   logic [15:0]           ops_count;

   logic [WIDTH-1:0] a_op [NREQ];
   logic [WIDTH-1:0] b_op [NREQ];

   assign req_a = {a_op[3], a_op[2], a_op[1], a_op[0]};
   assign req_b = {b_op[3], b_op[2], b_op[1], b_op[0]};

   always #5 clk = ~clk;

   and16_rr_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
      .req_ready(req_ready), .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_out(resp_out), .resp_id(resp_id), .rr_ptr(rr_ptr), .ops_count(ops_count)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference state: what the buffer and arbiter should hold.
   logic        m_valid;
   logic [15:0] m_out;
   int          m_id;
   int          m_ptr;
   int          m_cnt;
   int          last_grant;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Winner = valid requester with the smallest cyclic distance from the pointer.
   function automatic int exp_grant();
      int best, bestd, d;
      best = -1;
      bestd = NREQ + 1;
      if (m_valid && !resp_ready) return -1;
      for (int i = 0; i < NREQ; i++) begin
         if (req_valid[i]) begin
            d = (i - m_ptr + NREQ) % NREQ;
            if (d < bestd) begin
               bestd = d;
               best  = i;
            end
         end
      end
      return best;
   endfunction

   task automatic model_reset();
      m_valid = 1'b0; m_out = '0; m_id = 0; m_ptr = 0; m_cnt = 0;
   endtask

   task automatic chk_outputs();
      chk("resp_valid", 32'(resp_valid), 32'(m_valid));
      chk("resp_out",   32'(resp_out),   32'(m_out));
      chk("resp_id",    32'(resp_id),    32'(m_id));
      chk("rr_ptr",     32'(rr_ptr),     32'(m_ptr));
      chk("ops_count",  32'(ops_count),  32'(m_cnt));
   endtask

   // Inputs already driven; check grant, clock once, check registered outputs.
   task automatic step();
      int g;
      #1;
      g = exp_grant();
      last_grant = g;
      chk("req_ready", 32'(req_ready), (g < 0) ? 32'd0 : (32'd1 << g));
      @(posedge clk);
      #1;
      if (g >= 0) begin
         m_valid = 1'b1;
         m_out   = a_op[g] & b_op[g];
         m_id    = g;
         m_ptr   = (g + 1) % NREQ;
         m_cnt   = (m_cnt + 1) % 65536;
      end else if (resp_ready) begin
         m_valid = 1'b0;
      end
      chk_outputs();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      model_reset();
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk_outputs();
      @(posedge clk);
      #3;
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b0; req_valid = '0; resp_ready = 1'b0;
      for (int i = 0; i < NREQ; i++) begin a_op[i] = '0; b_op[i] = '0; end
      model_reset();
      #2;
      req_valid = 4'b1111;
      do_reset();

      // 1. Single requester
      req_valid = 4'b0001; a_op[0] = 16'h00FF; b_op[0] = 16'hFFFF; resp_ready = 1'b1;
      step();
      chk("t1_out", 32'(resp_out), 32'h00FF);
      chk("t1_ptr", 32'(rr_ptr), 32'd1);
      chk("t1_cnt", 32'(ops_count), 32'd1);
      req_valid = '0;
      step();

      // 2. Round-robin with all requesters asserting
      do_reset();
      for (int i = 0; i < NREQ; i++) begin
         a_op[i] = 16'hFFFF; b_op[i] = 16'(16'h1111 * (i + 1));
      end
      req_valid = 4'b1111; resp_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         step();
         chk("t2_id", 32'(resp_id), 32'(k % NREQ));
         chk("t2_out", 32'(resp_out), 32'(16'h1111 * ((k % NREQ) + 1)));
      end

      // 3. Backpressure with no bubble on release
      do_reset();
      req_valid = 4'b0110; resp_ready = 1'b1;
      step();
      chk("t3_first", 32'(resp_out), 32'h2222);
      req_valid = 4'b0100; resp_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         chk("t3_hold", 32'(resp_out), 32'h2222);
      end
      resp_ready = 1'b1;
      step();
      chk("t3_next", 32'(resp_out), 32'h3333);
      chk("t3_ptr", 32'(rr_ptr), 32'd3);

      // 4. Pointer skip from 3 to requester 1
      req_valid = 4'b0010;
      step();
      chk("t4_id", 32'(resp_id), 32'd1);
      chk("t4_ptr", 32'(rr_ptr), 32'd2);

      // 5. Asynchronous reset mid-operation
      req_valid = 4'b0001; resp_ready = 1'b0;
      step();
      req_valid = '0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      model_reset();
      chk("t5_async_valid", 32'(resp_valid), 32'd0);
      chk_outputs();
      @(negedge clk);
      rst = 1'b0;
      req_valid = 4'b1000; a_op[3] = 16'h1234; b_op[3] = 16'hFF00; resp_ready = 1'b1;
      step();
      chk("t5_id", 32'(resp_id), 32'd3);
      chk("t5_ptr", 32'(rr_ptr), 32'd0);

      // Random traffic; operands only change once granted or idle.
      for (int k = 0; k < 400; k++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!req_valid[i] || last_grant == i) begin
               a_op[i] = 16'($urandom);
               b_op[i] = 16'($urandom);
            end
         end
         req_valid  = 4'($urandom);
         resp_ready = ($urandom_range(0, 3) != 0);
         step();
      end

      // 6. Counter wrap
      do_reset();
      req_valid = 4'b0001; resp_ready = 1'b1; a_op[0] = 16'h5A5A; b_op[0] = 16'hFFFF;
      repeat (65535) begin
         @(posedge clk);
      end
      #1;
      m_valid = 1'b1; m_out = 16'h5A5A; m_id = 0; m_ptr = 1; m_cnt = 65535;
      chk_outputs();
      chk("t6_pre", 32'(ops_count), 32'hFFFF);
      a_op[0] = 16'hAAAA; b_op[0] = 16'h0F0F;
      step();
      chk("t6_wrap", 32'(ops_count), 32'h0000);
      chk("t6_out", 32'(resp_out), 32'h0A0A);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule
